// File: rtl/core_mem_arb_if.sv
// Requester and external-bus signal bundle for core_mem_arb.
// slave is the arbiter's view; master is the view of the core/bus environment.
interface core_mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  IMEM_REQ;
  logic [ADDR_W-1:0]     IMEM_ADDR;
  logic [DATA_W-1:0]     IMEM_RDATA;
  logic                  IMEM_BUSY;
  logic                  IMEM_DONE;

  logic                  DMEM_REQ;
  logic                  DMEM_WE;
  logic [DATA_W/8-1:0]   DMEM_WSTRB;
  logic [ADDR_W-1:0]     DMEM_ADDR;
  logic [DATA_W-1:0]     DMEM_WDATA;
  logic [DATA_W-1:0]     DMEM_RDATA;
  logic                  DMEM_BUSY;
  logic                  DMEM_DONE;

  logic                  BUS_VALID;
  logic                  BUS_WE;
  logic [DATA_W/8-1:0]   BUS_WSTRB;
  logic [ADDR_W-1:0]     BUS_ADDR;
  logic [DATA_W-1:0]     BUS_WDATA;
  logic                  BUS_READY;
  logic [DATA_W-1:0]     BUS_RDATA;

  logic                  ARB_ERR;

  modport slave (
    input  IMEM_REQ, IMEM_ADDR,
    input  DMEM_REQ, DMEM_WE, DMEM_WSTRB, DMEM_ADDR, DMEM_WDATA,
    input  BUS_READY, BUS_RDATA,
    output IMEM_RDATA, IMEM_BUSY, IMEM_DONE,
    output DMEM_RDATA, DMEM_BUSY, DMEM_DONE,
    output BUS_VALID, BUS_WE, BUS_WSTRB, BUS_ADDR, BUS_WDATA,
    output ARB_ERR
  );

  modport master (
    output IMEM_REQ, IMEM_ADDR,
    output DMEM_REQ, DMEM_WE, DMEM_WSTRB, DMEM_ADDR, DMEM_WDATA,
    output BUS_READY, BUS_RDATA,
    input  IMEM_RDATA, IMEM_BUSY, IMEM_DONE,
    input  DMEM_RDATA, DMEM_BUSY, DMEM_DONE,
    input  BUS_VALID, BUS_WE, BUS_WSTRB, BUS_ADDR, BUS_WDATA,
    input  ARB_ERR
  );
endinterface

// File: rtl/core_mem_arb.sv
// Shares one external memory bus between instruction fetch and load/store,
// with alternating priority on contention and a transfer timeout.
module core_mem_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          NRST,
  core_mem_arb_if.slave mem
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    I_XFER,
    D_XFER
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } side_t;

  state_t state, state_nxt;
  side_t  last_grant, last_grant_nxt;

  logic [CNT_W-1:0]  wait_cnt;
  logic              i_req, d_req;
  logic              grant_i, grant_d;
  logic              finish, expired;

  logic              imem_done, dmem_done, arb_err;
  logic [DATA_W-1:0] imem_rdata, dmem_rdata;
  logic              bus_we;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;

  always_comb begin
    // A request still held in its own DONE cycle is the old one, not a new one.
    i_req          = mem.IMEM_REQ & ~imem_done;
    d_req          = mem.DMEM_REQ & ~dmem_done;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    finish         = 1'b0;
    expired        = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || last_grant == OWN_I)) begin
          grant_d        = 1'b1;
          state_nxt      = D_XFER;
          last_grant_nxt = OWN_D;
        end else if (i_req) begin
          grant_i        = 1'b1;
          state_nxt      = I_XFER;
          last_grant_nxt = OWN_I;
        end
      end
      I_XFER, D_XFER: begin
        finish  = mem.BUS_READY;
        expired = (TIMEOUT != 0) && !mem.BUS_READY && (wait_cnt == CNT_LAST);
        if (finish || expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      last_grant <= OWN_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wait_cnt   <= '0;
      imem_done  <= 1'b0;
      dmem_done  <= 1'b0;
      arb_err    <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
      bus_we     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
      arb_err   <= 1'b0;

      if (grant_i) begin
        wait_cnt  <= '0;
        bus_addr  <= mem.IMEM_ADDR;
        bus_we    <= 1'b0;
        bus_wstrb <= '0;
        bus_wdata <= '0;
      end

      if (grant_d) begin
        wait_cnt  <= '0;
        bus_addr  <= mem.DMEM_ADDR;
        bus_we    <= mem.DMEM_WE;
        bus_wstrb <= mem.DMEM_WE ? mem.DMEM_WSTRB : '0;
        bus_wdata <= mem.DMEM_WE ? mem.DMEM_WDATA : '0;
      end

      if (finish || expired) begin
        wait_cnt <= '0;
        arb_err  <= expired;
        if (state == I_XFER) begin
          imem_done  <= 1'b1;
          imem_rdata <= expired ? '0 : mem.BUS_RDATA;
        end else begin
          dmem_done <= 1'b1;
          if (!bus_we) dmem_rdata <= expired ? '0 : mem.BUS_RDATA;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign mem.BUS_VALID  = (state != IDLE);
  assign mem.BUS_WE     = bus_we;
  assign mem.BUS_WSTRB  = bus_wstrb;
  assign mem.BUS_ADDR   = bus_addr;
  assign mem.BUS_WDATA  = bus_wdata;

  assign mem.IMEM_RDATA = imem_rdata;
  assign mem.IMEM_DONE  = imem_done;
  assign mem.DMEM_RDATA = dmem_rdata;
  assign mem.DMEM_DONE  = dmem_done;
  assign mem.ARB_ERR    = arb_err;

  // Gated by NRST so every output reads 0 while reset is held.
  assign mem.IMEM_BUSY  = mem.IMEM_REQ & ~imem_done & NRST;
  assign mem.DMEM_BUSY  = mem.DMEM_REQ & ~dmem_done & NRST;

endmodule

// File: tb/tb_core_mem_arb.sv
// Bench for core_mem_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_core_mem_arb;

  localparam int unsigned TO = 4;

  logic clk;
  logic nrst;
  int   n_cmp = 0;
  int   n_bad = 0;

  core_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  core_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK  (clk),
    .NRST (nrst),
    .mem  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), who won last, stall count.
  int          owner = 0;
  int          last  = 1;
  int          waitc = 0;
  bit          e_idone = 0, e_ddone = 0, e_err = 0, e_we = 0;
  logic [31:0] e_irdata = '0, e_drdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin : model
    bit ir, dr, fin, err;
    int g;
    logic [31:0] data;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        owner = 0; last = 1; waitc = 0;
        e_idone = 0; e_ddone = 0; e_err = 0; e_we = 0;
        e_irdata = '0; e_drdata = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      end else begin
        ir = bus_if.IMEM_REQ && !e_idone;
        dr = bus_if.DMEM_REQ && !e_ddone;
        e_idone = 0; e_ddone = 0; e_err = 0;
        if (owner == 0) begin
          if (ir && dr) g = (last == 1) ? 2 : 1;
          else          g = dr ? 2 : (ir ? 1 : 0);
          if (g == 1) begin
            owner = 1; last = 1; waitc = 0;
            e_addr = bus_if.IMEM_ADDR; e_we = 0; e_wstrb = '0; e_wdata = '0;
          end else if (g == 2) begin
            owner = 2; last = 2; waitc = 0;
            e_addr  = bus_if.DMEM_ADDR;
            e_we    = bus_if.DMEM_WE;
            e_wstrb = bus_if.DMEM_WE ? bus_if.DMEM_WSTRB : 4'h0;
            e_wdata = bus_if.DMEM_WE ? bus_if.DMEM_WDATA : 32'h0;
          end
        end else begin
          if (bus_if.BUS_READY) begin
            fin = 1; err = 0;
          end else begin
            waitc++;
            fin = (TO != 0) && (waitc == TO);
            err = fin;
          end
          if (fin) begin
            data = err ? 32'h0 : bus_if.BUS_RDATA;
            if (owner == 1) begin
              e_idone = 1; e_irdata = data;
            end else begin
              e_ddone = 1;
              if (!e_we) e_drdata = data;
            end
            e_err = err;
            owner = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("bus_valid",  bus_if.BUS_VALID,  32'(owner != 0));
      chk("imem_done",  bus_if.IMEM_DONE,  32'(e_idone));
      chk("dmem_done",  bus_if.DMEM_DONE,  32'(e_ddone));
      chk("arb_err",    bus_if.ARB_ERR,    32'(e_err));
      chk("imem_rdata", bus_if.IMEM_RDATA, e_irdata);
      chk("dmem_rdata", bus_if.DMEM_RDATA, e_drdata);
      chk("imem_busy",  bus_if.IMEM_BUSY,  32'(bus_if.IMEM_REQ && !e_idone && nrst));
      chk("dmem_busy",  bus_if.DMEM_BUSY,  32'(bus_if.DMEM_REQ && !e_ddone && nrst));
      if (owner != 0) begin
        chk("bus_addr",  bus_if.BUS_ADDR,  e_addr);
        chk("bus_we",    bus_if.BUS_WE,    32'(e_we));
        chk("bus_wstrb", bus_if.BUS_WSTRB, 32'(e_wstrb));
        chk("bus_wdata", bus_if.BUS_WDATA, e_wdata);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int mode;
    nrst = 1'b0;
    bus_if.IMEM_REQ = 0; bus_if.IMEM_ADDR = '0;
    bus_if.DMEM_REQ = 0; bus_if.DMEM_WE = 0; bus_if.DMEM_WSTRB = '0;
    bus_if.DMEM_ADDR = '0; bus_if.DMEM_WDATA = '0;
    bus_if.BUS_READY = 0; bus_if.BUS_RDATA = '0;
    repeat (3) tick();
    chk("rst_valid", bus_if.BUS_VALID, 0);
    chk("rst_idone", bus_if.IMEM_DONE, 0);
    chk("rst_drdata", bus_if.DMEM_RDATA, 0);
    chk("rst_err", bus_if.ARB_ERR, 0);

    // Contention: both held high, expect D,I,D,I.
    nrst = 1'b1;
    bus_if.IMEM_REQ = 1; bus_if.IMEM_ADDR = 32'h200;
    bus_if.DMEM_REQ = 1; bus_if.DMEM_WE = 0; bus_if.DMEM_ADDR = 32'h300;
    bus_if.BUS_READY = 1; bus_if.BUS_RDATA = 32'hA5A5_0001;
    tick();
    chk("tie1_valid", bus_if.BUS_VALID, 1);
    chk("tie1_addr", bus_if.BUS_ADDR, 32'h300);
    tick();
    chk("tie1_ddone", bus_if.DMEM_DONE, 1);
    chk("tie1_drdata", bus_if.DMEM_RDATA, 32'hA5A5_0001);
    chk("tie1_gap", bus_if.BUS_VALID, 0);
    chk("tie1_ibusy", bus_if.IMEM_BUSY, 1);
    chk("tie1_dbusy", bus_if.DMEM_BUSY, 0);
    tick();
    chk("tie2_addr", bus_if.BUS_ADDR, 32'h200);
    chk("tie2_ddone", bus_if.DMEM_DONE, 0);
    tick();
    chk("tie2_idone", bus_if.IMEM_DONE, 1);
    chk("tie2_irdata", bus_if.IMEM_RDATA, 32'hA5A5_0001);
    tick();
    chk("tie3_addr", bus_if.BUS_ADDR, 32'h300);
    tick();
    tick();
    chk("tie4_addr", bus_if.BUS_ADDR, 32'h200);
    tick();
    bus_if.BUS_READY = 0;
    tick();
    chk("mid_d_addr", bus_if.BUS_ADDR, 32'h300);
    chk("mid_d_valid", bus_if.BUS_VALID, 1);

    // Reset in the middle of a data transfer.
    nrst = 1'b0;
    #1;
    chk("arst_valid", bus_if.BUS_VALID, 0);
    chk("arst_addr", bus_if.BUS_ADDR, 0);
    chk("arst_ibusy", bus_if.IMEM_BUSY, 0);
    chk("arst_dbusy", bus_if.DMEM_BUSY, 0);
    chk("arst_ddone", bus_if.DMEM_DONE, 0);
    chk("arst_drdata", bus_if.DMEM_RDATA, 0);
    chk("arst_irdata", bus_if.IMEM_RDATA, 0);
    tick();
    nrst = 1'b1; bus_if.BUS_READY = 1;
    tick();
    chk("post_rst_tie", bus_if.BUS_ADDR, 32'h300);
    bus_if.IMEM_REQ = 0; bus_if.DMEM_REQ = 0;
    tick();
    chk("post_rst_ddone", bus_if.DMEM_DONE, 1);
    tick();

    // Single fetch with REQ held through DONE.
    bus_if.IMEM_REQ = 1; bus_if.IMEM_ADDR = 32'h100; bus_if.BUS_RDATA = 32'h0000_0013;
    tick();
    chk("fetch_valid", bus_if.BUS_VALID, 1);
    chk("fetch_addr", bus_if.BUS_ADDR, 32'h100);
    chk("fetch_we", bus_if.BUS_WE, 0);
    tick();
    chk("fetch_done", bus_if.IMEM_DONE, 1);
    chk("fetch_rdata", bus_if.IMEM_RDATA, 32'h13);
    chk("fetch_drop", bus_if.BUS_VALID, 0);
    tick();
    chk("held_nodup", bus_if.BUS_VALID, 0);
    chk("held_done0", bus_if.IMEM_DONE, 0);
    tick();
    chk("held_regrant", bus_if.BUS_VALID, 1);
    bus_if.IMEM_REQ = 0;
    tick();
    tick();

    // Load, then a stalled store that must leave DMEM_RDATA alone.
    bus_if.DMEM_REQ = 1; bus_if.DMEM_WE = 0; bus_if.DMEM_ADDR = 32'h380;
    bus_if.BUS_RDATA = 32'h1234_5678;
    tick();
    tick();
    chk("load_done", bus_if.DMEM_DONE, 1);
    chk("load_rdata", bus_if.DMEM_RDATA, 32'h1234_5678);
    bus_if.DMEM_WE = 1; bus_if.DMEM_WSTRB = 4'b0011; bus_if.DMEM_WDATA = 32'hDEAD_BEEF;
    bus_if.DMEM_ADDR = 32'h400; bus_if.BUS_READY = 0; bus_if.BUS_RDATA = 32'hFFFF_FFFF;
    tick();
    chk("store_gap", bus_if.BUS_VALID, 0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("store_valid", bus_if.BUS_VALID, 1);
      chk("store_we", bus_if.BUS_WE, 1);
      chk("store_wstrb", bus_if.BUS_WSTRB, 32'h3);
      chk("store_wdata", bus_if.BUS_WDATA, 32'hDEAD_BEEF);
      chk("store_addr", bus_if.BUS_ADDR, 32'h400);
      bus_if.DMEM_WDATA = 32'h0;
      if (k == 4) begin
        bus_if.BUS_READY = 1; bus_if.DMEM_REQ = 0;
      end
      tick();
    end
    chk("store_done", bus_if.DMEM_DONE, 1);
    chk("store_rdata", bus_if.DMEM_RDATA, 32'h1234_5678);
    chk("store_noerr", bus_if.ARB_ERR, 0);
    tick();

    // Timeout on a load with READY held low.
    bus_if.DMEM_REQ = 1; bus_if.DMEM_WE = 0; bus_if.DMEM_ADDR = 32'h500;
    bus_if.BUS_READY = 0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("to_valid", bus_if.BUS_VALID, 1);
      chk("to_err0", bus_if.ARB_ERR, 0);
      tick();
    end
    chk("to_drop", bus_if.BUS_VALID, 0);
    chk("to_done", bus_if.DMEM_DONE, 1);
    chk("to_err", bus_if.ARB_ERR, 1);
    chk("to_rdata", bus_if.DMEM_RDATA, 0);
    bus_if.DMEM_REQ = 0;
    tick();
    chk("to_err_pulse", bus_if.ARB_ERR, 0);

    // Randomized traffic; the compare process checks every cycle.
    mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!nrst) nrst = 1'b1;
      else if ($urandom_range(0, 699) == 0) nrst = 1'b0;
      if (cyc % 60 == 0) mode = $urandom_range(0, 2);
      case (mode)
        1:       bus_if.BUS_READY = 1;
        2:       bus_if.BUS_READY = ($urandom_range(0, 19) == 0);
        default: bus_if.BUS_READY = $urandom_range(0, 1);
      endcase
      bus_if.BUS_RDATA = $urandom;

      if (!bus_if.IMEM_REQ) begin
        bus_if.IMEM_REQ  = ($urandom_range(0, 2) == 0);
        bus_if.IMEM_ADDR = $urandom;
      end else if (bus_if.IMEM_DONE) begin
        bus_if.IMEM_REQ  = $urandom_range(0, 1);
        bus_if.IMEM_ADDR = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        bus_if.IMEM_ADDR = $urandom;
      end

      if (!bus_if.DMEM_REQ || bus_if.DMEM_DONE) begin
        bus_if.DMEM_REQ = !bus_if.DMEM_REQ ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
        bus_if.DMEM_WE    = $urandom_range(0, 1);
        bus_if.DMEM_WSTRB = 4'($urandom);
        bus_if.DMEM_ADDR  = $urandom;
        bus_if.DMEM_WDATA = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        bus_if.DMEM_WE    = $urandom_range(0, 1);
        bus_if.DMEM_WSTRB = 4'($urandom);
        bus_if.DMEM_ADDR  = $urandom;
        bus_if.DMEM_WDATA = $urandom;
      end
    end
    nrst = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
